fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised next-generation program-counter / fetch controller for the 9-bit-ISA core.
//  Sits between Ctrl and InstROM and drives the instruction address every cycle.
//  Adds over the previous IF: an explicit run/halt FSM, stall, absolute jump,
//  call/return through a return-address stack (RAS), and a saturating cycle counter.
// PARAMETERS
//  PC_W       10   program-counter width; instruction address space is 2**PC_W
//  OFF_W      8    branch-offset magnitude width (sign carried separately)
//  RAS_D      4    return-address-stack depth in entries (>=1)
//  CNT_W      16   cycle-counter width
//  START_ADDR 0    PC value loaded on start
// PORTS
//  CLK        in   1      clock, posedge
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      synchronous (re)start pulse
//  halt_req   in   1      halt instruction decoded this cycle
//  stall      in   1      hold PC this cycle
//  branch_en  in   1      relative branch taken
//  bSIGN      in   1      1 = backward (PC - bOFFSET), 0 = forward (PC + bOFFSET)
//  bOFFSET    in   OFF_W  branch-offset magnitude
//  jump_en    in   1      absolute jump
//  jump_addr  in   PC_W   absolute target
//  call_en    in   1      call: push PC+1, then jump to jump_addr
//  ret_en     in   1      return: pop RAS top into PC
//  PC         out  PC_W   instruction address
//  running    out  1      FSM in RUN
//  halt       out  1      FSM in HALTED
//  ras_err    out  1      sticky RAS overflow/underflow/conflict flag
//  ras_cnt    out  $clog2(RAS_D+1)  RAS occupancy
//  cycle_ct   out  CNT_W  RUN cycles since start, saturating
// BEHAVIOUR
//  - reset_n=0 (async, any state): FSM=IDLE, PC=START_ADDR, ras_cnt=0, ras_err=0,
//    cycle_ct=0, running=0, halt=0. RAS storage is not cleared (occupancy gates it).
//  - FSM IDLE -> RUN on start. RUN -> HALTED on halt_req. HALTED -> RUN on start.
//    In RUN or HALTED, start restarts: PC=START_ADDR, ras_cnt=0, ras_err=0, cycle_ct=0.
//    In IDLE and HALTED, all control inputs except start are ignored and PC holds.
//  - start outranks every other input in the same cycle.
//  - RUN PC-update priority, one action per cycle, registered (new PC visible next cycle):
//    halt_req > stall > call_en&ret_en > ret_en > call_en > jump_en > branch_en > PC+1.
//    halt_req: PC holds; no RAS change. stall: PC holds; no RAS change.
//    call_en&ret_en together: ras_err<=1, PC<=PC+1, RAS unchanged.
//    ret_en: if ras_cnt>0 then PC<=top, ras_cnt--; else ras_err<=1, PC<=PC+1.
//    call_en: if ras_cnt<RAS_D then push PC+1, ras_cnt++, PC<=jump_addr;
//      else ras_err<=1, PC<=jump_addr, no push (call still taken).
//    jump_en: PC<=jump_addr.
//    branch_en: PC<=PC +/- zero-extended bOFFSET, modulo 2**PC_W (wraps both ways).
//  - PC+1 wraps from 2**PC_W-1 to 0. A pushed return address wraps the same way.
//  - ras_err is sticky; it clears only on reset_n or start.
//  - cycle_ct increments by 1 on every clock edge where FSM is RUN, including stall
//    cycles and the halt_req cycle. It saturates at 2**CNT_W-1 and holds in IDLE/HALTED.
//  - running and halt are decoded directly from the state register (no extra latency).
// STRUCTURE
//  - fetch_pkg: typedef enum logic[1:0] {IDLE, RUN, HALTED} fetch_state_t;
//    typedef enum pc_sel_t {SEL_HOLD, SEL_INC, SEL_BR, SEL_JMP, SEL_RET, SEL_START}.
//  - Sub-module ras_stack #(W=PC_W, D=RAS_D) provides push/pop/top/cnt/full/empty.
//    It ignores a push when full and a pop when empty, and resets cnt asynchronously.
//  - In fetch_unit: FSM, priority mux producing pc_sel_t, PC register, counter, error flag.
// TESTING
//  1. reset_n=0 mid-RUN with PC=0x155 -> same cycle: PC=0, running=0, cycle_ct=0, ras_cnt=0.
//  2. start, then 5 idle cycles -> PC=1,2,3,4,5; with PC_W=10 starting at 0x3FF -> next PC=0.
//  3. PC=0x002, branch_en, bSIGN=1, bOFFSET=5 -> PC=0x3FD; PC=0x3FE, bSIGN=0, bOFFSET=3 -> PC=0x001.
//  4. RAS_D=4: 5 calls to 0x100 from PC=0x010 -> ras_cnt=4, ras_err=1, PC=0x100;
//     then 4 returns -> last PC=0x011, ras_cnt=0; 5th return -> PC+1, ras_err stays 1.
//  5. stall+branch_en in same cycle -> PC holds, cycle_ct still +1; halt_req+call_en -> halt=1,
//     PC holds, ras_cnt unchanged; later branch inputs ignored; start -> PC=0, ras_err=0.
//  6. CNT_W=4: run 20 cycles -> cycle_ct=15 and holds; call_en&ret_en together -> ras_err=1, PC+1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
//  Module   : fetch_unit_pkg
//  Purpose  : Shared types for the fetch unit (FSM states, PC source select).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,
      SEL_INC   = 3'd1,
      SEL_BR    = 3'd2,
      SEL_JMP   = 3'd3,
      SEL_RET   = 3'd4,
      SEL_START = 3'd5
   } pc_sel_t;

endpackage : fetch_unit_pkg

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Control/status bundle between Ctrl (master) and the fetch unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
   parameter int PC_W  = 10,
   parameter int OFF_W = 8,
   parameter int RAS_D = 4,
   parameter int CNT_W = 16
);
   localparam int c_RAS_CW = $clog2(RAS_D + 1);

   logic                start;
   logic                halt_req;
   logic                stall;
   logic                branch_en;
   logic                bSIGN;
   logic [OFF_W-1:0]    bOFFSET;
   logic                jump_en;
   logic [PC_W-1:0]     jump_addr;
   logic                call_en;
   logic                ret_en;
   logic [PC_W-1:0]     PC;
   logic                running;
   logic                halt;
   logic                ras_err;
   logic [c_RAS_CW-1:0] ras_cnt;
   logic [CNT_W-1:0]    cycle_ct;

   modport master (
      output start, halt_req, stall, branch_en, bSIGN, bOFFSET,
             jump_en, jump_addr, call_en, ret_en,
      input  PC, running, halt, ras_err, ras_cnt, cycle_ct
   );

   modport slave (
      input  start, halt_req, stall, branch_en, bSIGN, bOFFSET,
             jump_en, jump_addr, call_en, ret_en,
      output PC, running, halt, ras_err, ras_cnt, cycle_ct
   );

endinterface : fetch_unit_if

`default_nettype wire

// File: rtl/fetch_unit_ras_stack.sv
// ============================================================================
//  Module   : fetch_unit_ras_stack
//  Purpose  : Return-address stack; push when full / pop when empty are ignored.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit_ras_stack #(
   parameter int W = 10,
   parameter int D = 4
) (
   input  wire logic                    clk,
   input  wire logic                    rst_n,
   input  wire logic                    i_clear,
   input  wire logic                    i_push,
   input  wire logic                    i_pop,
   input  wire logic [W-1:0]            i_din,
   output logic      [W-1:0]            o_top,
   output logic      [$clog2(D+1)-1:0]  o_cnt,
   output logic                         o_full,
   output logic                         o_empty
);
   localparam int c_CW = $clog2(D + 1);
   localparam int c_AW = (D > 1) ? $clog2(D) : 1;

   logic [W-1:0]    r_mem [D];
   logic [c_CW-1:0] r_cnt;
   logic [c_AW-1:0] w_wr_idx;
   logic [c_AW-1:0] w_top_idx;
   logic            w_do_push;
   logic            w_do_pop;

   assign o_full    = (r_cnt == c_CW'(D));
   assign o_empty   = (r_cnt == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_wr_idx  = c_AW'(r_cnt);
   assign w_top_idx = c_AW'(r_cnt - c_CW'(1));
   assign o_top     = o_empty ? '0 : r_mem[w_top_idx];
   assign o_cnt     = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (w_do_push && !w_do_pop) begin
         r_cnt <= r_cnt + c_CW'(1);
      end else if (w_do_pop && !w_do_push) begin
         r_cnt <= r_cnt - c_CW'(1);
      end
   end

   // Storage is never reset; occupancy alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (!i_clear) begin
         if (w_do_push && !w_do_pop) begin
            r_mem[w_wr_idx] <= i_din;
         end else if (w_do_push && w_do_pop) begin
            r_mem[w_top_idx] <= i_din;
         end
      end
   end

endmodule : fetch_unit_ras_stack

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : PC / fetch controller with run-halt FSM, branch, jump, call/return.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          PC_W       = 10,
   parameter int          OFF_W      = 8,
   parameter int          RAS_D      = 4,
   parameter int          CNT_W      = 16,
   parameter int unsigned START_ADDR = 0
) (
   input  wire logic   CLK,
   input  wire logic   reset_n,
   fetch_unit_if.slave bus
);
   localparam int              c_RAS_CW = $clog2(RAS_D + 1);
   localparam logic [PC_W-1:0] c_START  = PC_W'(START_ADDR);

   fetch_state_t        r_state;
   pc_sel_t             w_sel;
   logic [PC_W-1:0]     r_pc;
   logic [PC_W-1:0]     w_pc_nxt;
   logic [PC_W-1:0]     w_pc_inc;
   logic [PC_W-1:0]     w_off_ext;
   logic [PC_W-1:0]     w_pc_br;
   logic [PC_W-1:0]     w_ras_top;
   logic [c_RAS_CW-1:0] w_ras_cnt;
   logic                w_ras_full;
   logic                w_ras_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_err_set;
   logic                r_err;
   logic [CNT_W-1:0]    r_cycle;

   assign w_pc_inc  = r_pc + PC_W'(1);
   assign w_off_ext = PC_W'(bus.bOFFSET);
   assign w_pc_br   = bus.bSIGN ? (r_pc - w_off_ext) : (r_pc + w_off_ext);

   // One action per RUN cycle; start overrides everything in any state.
   always_comb begin
      w_sel     = SEL_HOLD;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err_set = 1'b0;
      if (bus.start) begin
         w_sel = SEL_START;
      end else if (r_state == RUN) begin
         if (bus.halt_req || bus.stall) begin
            w_sel = SEL_HOLD;
         end else if (bus.call_en && bus.ret_en) begin
            w_err_set = 1'b1;
            w_sel     = SEL_INC;
         end else if (bus.ret_en) begin
            if (!w_ras_empty) begin
               w_sel = SEL_RET;
               w_pop = 1'b1;
            end else begin
               w_err_set = 1'b1;
               w_sel     = SEL_INC;
            end
         end else if (bus.call_en) begin
            w_sel = SEL_JMP;
            if (!w_ras_full) begin
               w_push = 1'b1;
            end else begin
               w_err_set = 1'b1;
            end
         end else if (bus.jump_en) begin
            w_sel = SEL_JMP;
         end else if (bus.branch_en) begin
            w_sel = SEL_BR;
         end else begin
            w_sel = SEL_INC;
         end
      end
   end

   always_comb begin
      w_pc_nxt = r_pc;
      case (w_sel)
         SEL_INC:   w_pc_nxt = w_pc_inc;
         SEL_BR:    w_pc_nxt = w_pc_br;
         SEL_JMP:   w_pc_nxt = bus.jump_addr;
         SEL_RET:   w_pc_nxt = w_ras_top;
         SEL_START: w_pc_nxt = c_START;
         default:   w_pc_nxt = r_pc;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (bus.start) r_state <= RUN;
            RUN:     if (!bus.start && bus.halt_req) r_state <= HALTED;
            HALTED:  if (bus.start) r_state <= RUN;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_pc    <= c_START;
         r_err   <= 1'b0;
         r_cycle <= '0;
      end else begin
         r_pc <= w_pc_nxt;
         if (bus.start) begin
            r_err   <= 1'b0;
            r_cycle <= '0;
         end else begin
            if (w_err_set) begin
               r_err <= 1'b1;
            end
            if ((r_state == RUN) && (r_cycle != {CNT_W{1'b1}})) begin
               r_cycle <= r_cycle + CNT_W'(1);
            end
         end
      end
   end

   fetch_unit_ras_stack #(
      .W (PC_W),
      .D (RAS_D)
   ) u_ras (
      .clk     (CLK),
      .rst_n   (reset_n),
      .i_clear (bus.start),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_pc_inc),
      .o_top   (w_ras_top),
      .o_cnt   (w_ras_cnt),
      .o_full  (w_ras_full),
      .o_empty (w_ras_empty)
   );

   assign bus.PC       = r_pc;
   assign bus.running  = (r_state == RUN);
   assign bus.halt     = (r_state == HALTED);
   assign bus.ras_err  = r_err;
   assign bus.ras_cnt  = w_ras_cnt;
   assign bus.cycle_ct = r_cycle;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench; second DUT has a 4-bit cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic CLK;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   fetch_unit_if #(.PC_W(10), .OFF_W(8), .RAS_D(4), .CNT_W(16)) bus_a ();
   fetch_unit_if #(.PC_W(10), .OFF_W(8), .RAS_D(4), .CNT_W(4))  bus_b ();

   fetch_unit #(.PC_W(10), .OFF_W(8), .RAS_D(4), .CNT_W(16), .START_ADDR(0)) u_dut_a (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus_a.slave)
   );

   fetch_unit #(.PC_W(10), .OFF_W(8), .RAS_D(4), .CNT_W(4), .START_ADDR(0)) u_dut_b (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus_b.slave)
   );

   assign bus_b.start     = bus_a.start;
   assign bus_b.halt_req  = bus_a.halt_req;
   assign bus_b.stall     = bus_a.stall;
   assign bus_b.branch_en = bus_a.branch_en;
   assign bus_b.bSIGN     = bus_a.bSIGN;
   assign bus_b.bOFFSET   = bus_a.bOFFSET;
   assign bus_b.jump_en   = bus_a.jump_en;
   assign bus_b.jump_addr = bus_a.jump_addr;
   assign bus_b.call_en   = bus_a.call_en;
   assign bus_b.ret_en    = bus_a.ret_en;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_ctrl();
      bus_a.start     = 1'b0;
      bus_a.halt_req  = 1'b0;
      bus_a.stall     = 1'b0;
      bus_a.branch_en = 1'b0;
      bus_a.bSIGN     = 1'b0;
      bus_a.bOFFSET   = '0;
      bus_a.jump_en   = 1'b0;
      bus_a.jump_addr = '0;
      bus_a.call_en   = 1'b0;
      bus_a.ret_en    = 1'b0;
   endtask

   task automatic do_jump(input logic [9:0] addr);
      bus_a.jump_en   = 1'b1;
      bus_a.jump_addr = addr;
      tick();
      idle_ctrl();
   endtask

   initial begin
      idle_ctrl();
      reset_n = 1'b0;
      #12;
      check_eq("rst_pc",      32'(bus_a.PC),       32'h0);
      check_eq("rst_running", 32'(bus_a.running),  32'h0);
      check_eq("rst_halt",    32'(bus_a.halt),     32'h0);
      check_eq("rst_ras_cnt", 32'(bus_a.ras_cnt),  32'h0);
      check_eq("rst_ras_err", 32'(bus_a.ras_err),  32'h0);
      check_eq("rst_cycle",   32'(bus_a.cycle_ct), 32'h0);
      reset_n = 1'b1;

      // Start and free-run increments
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check_eq("start_pc",      32'(bus_a.PC),      32'h0);
      check_eq("start_running", 32'(bus_a.running), 32'h1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_eq("inc_pc", 32'(bus_a.PC), 32'(i));
      end
      check_eq("inc_cycle", 32'(bus_a.cycle_ct), 32'd5);

      // PC+1 wrap at top of address space
      do_jump(10'h3FF);
      check_eq("jmp_pc", 32'(bus_a.PC), 32'h3FF);
      tick();
      check_eq("wrap_pc", 32'(bus_a.PC), 32'h0);

      // Branches wrapping backward and forward
      do_jump(10'h002);
      bus_a.branch_en = 1'b1; bus_a.bSIGN = 1'b1; bus_a.bOFFSET = 8'd5;
      tick();
      idle_ctrl();
      check_eq("br_back_wrap", 32'(bus_a.PC), 32'h3FD);
      do_jump(10'h3FE);
      bus_a.branch_en = 1'b1; bus_a.bSIGN = 1'b0; bus_a.bOFFSET = 8'd3;
      tick();
      idle_ctrl();
      check_eq("br_fwd_wrap", 32'(bus_a.PC), 32'h001);
      check_eq("cycle_11", 32'(bus_a.cycle_ct), 32'd11);

      // Calls filling then overflowing the RAS
      do_jump(10'h010);
      bus_a.call_en = 1'b1; bus_a.jump_addr = 10'h100;
      for (int i = 1; i <= 4; i++) tick();
      check_eq("call4_cnt", 32'(bus_a.ras_cnt), 32'd4);
      check_eq("call4_err", 32'(bus_a.ras_err), 32'd0);
      tick();
      idle_ctrl();
      check_eq("call5_cnt", 32'(bus_a.ras_cnt), 32'd4);
      check_eq("call5_err", 32'(bus_a.ras_err), 32'd1);
      check_eq("call5_pc",  32'(bus_a.PC),      32'h100);

      // Returns unwind the pushed addresses
      bus_a.ret_en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_eq("ret_pc_inner", 32'(bus_a.PC), 32'h101);
      end
      tick();
      check_eq("ret4_pc",  32'(bus_a.PC),      32'h011);
      check_eq("ret4_cnt", 32'(bus_a.ras_cnt), 32'd0);
      tick();
      idle_ctrl();
      check_eq("ret_underflow_pc",  32'(bus_a.PC),      32'h012);
      check_eq("ret_underflow_err", 32'(bus_a.ras_err), 32'd1);
      check_eq("cycle_22", 32'(bus_a.cycle_ct), 32'd22);

      // Stall outranks branch
      bus_a.stall = 1'b1; bus_a.branch_en = 1'b1; bus_a.bOFFSET = 8'd7;
      tick();
      idle_ctrl();
      check_eq("stall_pc",    32'(bus_a.PC),       32'h012);
      check_eq("stall_cycle", 32'(bus_a.cycle_ct), 32'd23);

      bus_a.call_en = 1'b1; bus_a.jump_addr = 10'h050;
      tick();
      idle_ctrl();
      check_eq("call_pc",  32'(bus_a.PC),      32'h050);
      check_eq("call_cnt", 32'(bus_a.ras_cnt), 32'd1);

      // Halt outranks call; HALTED ignores controls
      bus_a.halt_req = 1'b1; bus_a.call_en = 1'b1; bus_a.jump_addr = 10'h200;
      tick();
      idle_ctrl();
      check_eq("halt_flag",    32'(bus_a.halt),     32'd1);
      check_eq("halt_running", 32'(bus_a.running),  32'd0);
      check_eq("halt_pc",      32'(bus_a.PC),       32'h050);
      check_eq("halt_cnt",     32'(bus_a.ras_cnt),  32'd1);
      check_eq("halt_cycle",   32'(bus_a.cycle_ct), 32'd25);
      bus_a.branch_en = 1'b1; bus_a.bOFFSET = 8'd9; bus_a.jump_en = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      idle_ctrl();
      check_eq("halted_pc",    32'(bus_a.PC),       32'h050);
      check_eq("halted_cycle", 32'(bus_a.cycle_ct), 32'd25);
      check_eq("halted_err",   32'(bus_a.ras_err),  32'd1);

      // Restart from HALTED
      bus_a.start = 1'b1; bus_a.branch_en = 1'b1; bus_a.bOFFSET = 8'd4;
      tick();
      idle_ctrl();
      check_eq("restart_pc",      32'(bus_a.PC),       32'h0);
      check_eq("restart_err",     32'(bus_a.ras_err),  32'd0);
      check_eq("restart_cnt",     32'(bus_a.ras_cnt),  32'd0);
      check_eq("restart_running", 32'(bus_a.running),  32'd1);
      check_eq("restart_cycle",   32'(bus_a.cycle_ct), 32'd0);

      // Saturating counter on the narrow DUT
      for (int i = 0; i < 20; i++) tick();
      check_eq("run20_pc",    32'(bus_a.PC),       32'd20);
      check_eq("run20_cyc_a", 32'(bus_a.cycle_ct), 32'd20);
      check_eq("run20_cyc_b", 32'(bus_b.cycle_ct), 32'd15);
      tick();
      check_eq("sat_cyc_a", 32'(bus_a.cycle_ct), 32'd21);
      check_eq("sat_cyc_b", 32'(bus_b.cycle_ct), 32'd15);

      // Call and return together
      bus_a.call_en = 1'b1; bus_a.ret_en = 1'b1; bus_a.jump_addr = 10'h300;
      tick();
      idle_ctrl();
      check_eq("callret_pc",  32'(bus_a.PC),      32'd22);
      check_eq("callret_err", 32'(bus_a.ras_err), 32'd1);
      check_eq("callret_cnt", 32'(bus_a.ras_cnt), 32'd0);

      // Asynchronous reset mid-RUN
      bus_a.call_en = 1'b1; bus_a.jump_addr = 10'h155;
      tick();
      idle_ctrl();
      check_eq("pre_rst_pc",  32'(bus_a.PC),      32'h155);
      check_eq("pre_rst_cnt", 32'(bus_a.ras_cnt), 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("arst_pc",      32'(bus_a.PC),       32'h0);
      check_eq("arst_running", 32'(bus_a.running),  32'd0);
      check_eq("arst_cycle",   32'(bus_a.cycle_ct), 32'd0);
      check_eq("arst_cnt",     32'(bus_a.ras_cnt),  32'd0);
      check_eq("arst_err",     32'(bus_a.ras_err),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fetch_unit

`default_nettype wire
